// File: rtl/d_flip_flop_pkg.sv
// Shared constants for the d_flip_flop register chain.
// Optional feature macro used by this block: D_FLIP_FLOP_CE_EN (adds clock enable).
package d_flip_flop_pkg;

    // Default geometry: a single one-bit register.
    localparam int DFF_DEFAULT_WIDTH  = 1;
    localparam int DFF_DEFAULT_STAGES = 1;

    // Level of rst that forces the reset value into the stages.
    localparam logic RST_ACTIVE = 1'b0;

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop_stage.sv
// One WIDTH-bit register stage with synchronous active-low reset.
// Macro D_FLIP_FLOP_CE_EN adds an active-high clock enable (ce); reset ignores ce.
module d_flip_flop_stage
    import d_flip_flop_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef D_FLIP_FLOP_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

`ifdef D_FLIP_FLOP_CE_EN
    // Reset dominates; otherwise load only when enabled, else hold.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            q <= RESET_VALUE;
        end else if (ce) begin
            q <= d;
        end
    end
`else
    // Reset dominates; otherwise load on every rising edge.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end
`endif

endmodule : d_flip_flop_stage

// File: rtl/d_flip_flop.sv
// Parameterised D-type register chain: q is data delayed by STAGES rising edges.
// With STAGES >= 2 it also serves as a synchroniser. Every stage resets to
// RESET_VALUE on any edge with rst low, so a reset flushes all in-flight data.
// Macro D_FLIP_FLOP_CE_EN adds input ce (after rst); when undefined the chain
// loads on every edge.
module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter int               STAGES      = DFF_DEFAULT_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef D_FLIP_FLOP_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    // Reject illegal geometry while elaborating rather than building a broken chain.
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "d_flip_flop: WIDTH must be >= 1");
    end
    if (STAGES < 1) begin : g_bad_stages
        $fatal(1, "d_flip_flop: STAGES must be >= 1");
    end

    // Output of each stage; entry STAGES-1 drives q.
    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d;

        // Stage boundary: stage 0 samples data, later stages sample their predecessor.
        if (i == 0) begin : g_first
            assign stage_d = data;
        end else begin : g_next
            assign stage_d = stage_q[i-1];
        end

        d_flip_flop_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk (clk),
            .rst (rst),
`ifdef D_FLIP_FLOP_CE_EN
            .ce  (ce),
`endif
            .d   (stage_d),
            .q   (stage_q[i])
        );
    end

    assign q = stage_q[STAGES-1];

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: a 1-bit single-stage instance and an
// 8-bit three-stage instance with reset value 8'hA5. Clock-enable checks are
// compiled only when D_FLIP_FLOP_CE_EN is defined.
module tb_d_flip_flop;

    logic       clk;
    logic       rst1;
    logic [0:0] data1;
    logic [0:0] q1;
    logic       rst8;
    logic [7:0] data8;
    logic [7:0] q8;
`ifdef D_FLIP_FLOP_CE_EN
    logic       ce1;
    logic       ce8;
`endif

    int checks   = 0;
    int failures = 0;

    d_flip_flop #(
        .WIDTH       (1),
        .STAGES      (1),
        .RESET_VALUE (1'b0)
    ) u_dut1 (
        .clk  (clk),
        .rst  (rst1),
`ifdef D_FLIP_FLOP_CE_EN
        .ce   (ce1),
`endif
        .data (data1),
        .q    (q1)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .STAGES      (3),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk  (clk),
        .rst  (rst8),
`ifdef D_FLIP_FLOP_CE_EN
        .ce   (ce8),
`endif
        .data (data8),
        .q    (q8)
    );

    // 10-unit period: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where inputs are changed.
    task automatic to_negedge();
        @(negedge clk);
    endtask

    // {rst, data, expected q} for the 1-bit instance, order scrambled by hand.
    logic [2:0] pairs [8] = '{3'b01_0, 3'b11_1, 3'b00_0, 3'b10_0,
                              3'b11_1, 3'b01_0, 3'b10_0, 3'b00_0};
    logic [0:0] cap_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        rst1  = 1'b0;
        data1 = 1'b1;
        rst8  = 1'b0;
        data8 = 8'h3C;
`ifdef D_FLIP_FLOP_CE_EN
        ce1   = 1'b1;
        ce8   = 1'b1;
`endif

        // Reset held for two edges with data=1 must keep q at 0.
        tick();
        check("reset_edge1", {7'd0, q1}, 8'h00);
        check("reset8_edge1", q8, 8'hA5);
        tick();
        check("reset_edge2", {7'd0, q1}, 8'h00);

        // Basic capture: data changes on falling edges, seen at the next rising edge.
        to_negedge();
        rst1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data1 = cap_seq[i];
            tick();
            check($sformatf("capture_%0d", i), {7'd0, q1}, {7'd0, cap_seq[i]});
            to_negedge();
        end

        // Glitch on data between edges must not move q.
        data1 = 1'b0;
        tick();
        data1 = 1'b1;
        #2;
        data1 = 1'b0;
        #1;
        check("hold_between_edges", {7'd0, q1}, 8'h00);
        to_negedge();

        // All {rst,data} combinations, reset asserted mid-stream.
        for (int i = 0; i < 8; i++) begin
            rst1  = pairs[i][2];
            data1 = pairs[i][1];
            tick();
            check($sformatf("pair_%0d", i), {7'd0, q1}, {7'd0, pairs[i][0]});
            to_negedge();
        end

        // Pipeline latency: 8'h3C for one cycle after release, then 8'h00.
        rst8  = 1'b0;
        data8 = 8'h3C;
        tick();
        check("pipe_reset", q8, 8'hA5);
        to_negedge();
        rst8 = 1'b1;
        tick();
        check("pipe_rel_e1", q8, 8'hA5);
        to_negedge();
        data8 = 8'h00;
        tick();
        check("pipe_rel_e2", q8, 8'hA5);
        tick();
        check("pipe_rel_e3", q8, 8'h3C);
        tick();
        check("pipe_rel_e4", q8, 8'h00);

        // Fill every stage with 8'h77, then one reset edge must flush them all.
        to_negedge();
        data8 = 8'h77;
        tick();
        tick();
        tick();
        check("pipe_fill", q8, 8'h77);
        to_negedge();
        rst8 = 1'b0;
        tick();
        check("flush_reset", q8, 8'hA5);
        to_negedge();
        rst8  = 1'b1;
        data8 = 8'h00;
        tick();
        check("flush_e1", q8, 8'hA5);
        tick();
        check("flush_e2", q8, 8'hA5);
        tick();
        check("flush_e3", q8, 8'h00);

`ifdef D_FLIP_FLOP_CE_EN
        // Load 8'h11, then ce=0 must hold it while data=8'hFF.
        to_negedge();
        data8 = 8'h11;
        ce8   = 1'b1;
        tick();
        tick();
        tick();
        check("ce_load", q8, 8'h11);
        to_negedge();
        ce8   = 1'b0;
        data8 = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ce_hold_%0d", i), q8, 8'h11);
        end
        // Reset still wins with ce low.
        to_negedge();
        rst8 = 1'b0;
        tick();
        check("ce_reset", q8, 8'hA5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_d_flip_flop
